// File: rtl/bridge_pkg.sv
// Shared state encoding, default address map and constants for sys_bus_bridge.
// No logic: types and localparams only.
// Imported by the bridge top; the decoder takes its map as parameters.
package bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bridge_state_e;

    localparam logic [31:0] DM_BASE     = 32'h0000_0000;
    localparam logic [31:0] DM_MASK     = 32'hFFFF_C000;
    localparam logic [31:0] TIMER0_BASE = 32'h0000_7F00;
    localparam logic [31:0] TIMER0_MASK = 32'hFFFF_FFF0;
    localparam logic [31:0] TIMER1_BASE = 32'h0000_7F10;
    localparam logic [31:0] TIMER1_MASK = 32'hFFFF_FFF0;

    localparam logic [31:0] DEAD_VALUE  = 32'h1837_3695;

    localparam int CNT_W    = $clog2(256);
    localparam int HW_INT_W = 6;

endpackage

// File: rtl/bridge_addr_decoder.sv
// Address window decoder: one-hot hit of the lowest-index matching slave.
// Latency: combinational.
// Backpressure: none.
module bridge_addr_decoder #(
    parameter int                        NUM_SLAVES = 3,
    parameter logic [NUM_SLAVES*32-1:0]  SLV_BASE   = {bridge_pkg::TIMER1_BASE,
                                                       bridge_pkg::TIMER0_BASE,
                                                       bridge_pkg::DM_BASE},
    parameter logic [NUM_SLAVES*32-1:0]  SLV_MASK   = {bridge_pkg::TIMER1_MASK,
                                                       bridge_pkg::TIMER0_MASK,
                                                       bridge_pkg::DM_MASK}
) (
    input  logic [31:0]           addr,
    output logic [NUM_SLAVES-1:0] hit,
    output logic                  any_hit
);

    always_comb begin
        hit     = '0;
        any_hit = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!any_hit && ((addr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32])) begin
                hit[i]  = 1'b1;
                any_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sys_bus_bridge.sv
// CPU data port to memory-mapped slaves bridge with wait-state handshake and timeout.
// Latency: 2 cycles minimum (+1 per slave wait state); unmapped completes in 1.
// Backpressure: slv_ready stretches ACCESS up to TIMEOUT cycles; CPU holds cpu_req until cpu_ready.
module sys_bus_bridge #(
    parameter int                        NUM_SLAVES = 3,
    parameter logic [NUM_SLAVES*32-1:0]  SLV_BASE   = {bridge_pkg::TIMER1_BASE,
                                                       bridge_pkg::TIMER0_BASE,
                                                       bridge_pkg::DM_BASE},
    parameter logic [NUM_SLAVES*32-1:0]  SLV_MASK   = {bridge_pkg::TIMER1_MASK,
                                                       bridge_pkg::TIMER0_MASK,
                                                       bridge_pkg::DM_MASK},
    parameter int                        TIMEOUT    = 15,
    parameter logic [31:0]               DEAD_VALUE = bridge_pkg::DEAD_VALUE
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [3:0]                   cpu_be,
    input  logic [31:0]                  cpu_addr,
    input  logic [31:0]                  cpu_wdata,
    output logic [31:0]                  cpu_rdata,
    output logic                         cpu_ready,
    output logic                         cpu_err,
    output logic [NUM_SLAVES-1:0]        slv_sel,
    output logic                         slv_we,
    output logic [3:0]                   slv_be,
    output logic [31:0]                  slv_addr,
    output logic [31:0]                  slv_wdata,
    input  logic [NUM_SLAVES*32-1:0]     slv_rdata,
    input  logic [NUM_SLAVES-1:0]        slv_ready,
    input  logic [NUM_SLAVES-1:0]        slv_irq,
    output logic [5:0]                   hw_int
);

    import bridge_pkg::*;

    localparam int              NIRQ    = (NUM_SLAVES < HW_INT_W) ? NUM_SLAVES : HW_INT_W;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    bridge_state_e          state, state_nxt;
    logic [NUM_SLAVES-1:0]  hit;
    logic                   any_hit;
    logic [CNT_W-1:0]       cnt;
    logic                   sel_ready;
    logic [31:0]            sel_rdata;
    logic                   start, done_ok, done_err;
    logic [HW_INT_W-1:0]    irq_ext;

    // Decode the live CPU address so the IDLE->ACCESS decision lands on the request edge.
    bridge_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_dec (
        .addr    (cpu_addr),
        .hit     (hit),
        .any_hit (any_hit)
    );

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (slv_sel[i]) begin
                sel_ready = sel_ready | slv_ready[i];
                sel_rdata = sel_rdata | slv_rdata[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        done_ok   = 1'b0;
        done_err  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_req) begin
                    start = 1'b1;
                    if (any_hit) begin
                        state_nxt = ST_ACCESS;
                    end else begin
                        state_nxt = ST_RESP;
                        done_err  = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                // Ready is checked first so a last-cycle response beats the timeout.
                if (sel_ready) begin
                    state_nxt = ST_RESP;
                    done_ok   = 1'b1;
                end else if (cnt == TO_LAST) begin
                    state_nxt = ST_RESP;
                    done_err  = 1'b1;
                end
            end
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slv_sel   <= '0;
            slv_we    <= 1'b0;
            slv_be    <= '0;
            slv_addr  <= '0;
            slv_wdata <= '0;
            cnt       <= '0;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            if (start) begin
                slv_we    <= cpu_we;
                slv_be    <= cpu_be;
                slv_addr  <= cpu_addr;
                slv_wdata <= cpu_wdata;
            end
            if (state_nxt != ST_ACCESS) slv_sel <= '0;
            else if (start)             slv_sel <= hit;

            cnt       <= (state == ST_ACCESS && state_nxt == ST_ACCESS) ? cnt + 1'b1 : '0;
            cpu_ready <= done_ok | done_err;
            cpu_err   <= done_err;
            // cpu_rdata is only rewritten on completion so it holds between accesses.
            if (done_ok)       cpu_rdata <= slv_we ? '0 : sel_rdata;
            else if (done_err) cpu_rdata <= DEAD_VALUE;
        end
    end

    always_comb begin
        irq_ext = '0;
        for (int k = 0; k < NIRQ; k++) irq_ext[k] = slv_irq[k];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hw_int <= '0;
        else          hw_int <= irq_ext;
    end

endmodule

// File: tb/tb_sys_bus_bridge.sv
// Bench for sys_bus_bridge: fixed vector table, hand-written corner sequences, random accesses vs a reference model.
module tb_sys_bus_bridge;

    localparam int          NS   = 3;
    localparam int          TO   = 15;
    localparam logic [31:0] DEAD = 32'h1837_3695;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cpu_req, cpu_we;
    logic [3:0]        cpu_be;
    logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata;
    logic              cpu_ready, cpu_err;
    logic [NS-1:0]     slv_sel, slv_ready, slv_irq;
    logic              slv_we;
    logic [3:0]        slv_be;
    logic [31:0]       slv_addr, slv_wdata;
    logic [NS*32-1:0]  slv_rdata;
    logic [5:0]        hw_int;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sys_bus_bridge #(.NUM_SLAVES(NS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
        .slv_sel(slv_sel), .slv_we(slv_we), .slv_be(slv_be), .slv_addr(slv_addr),
        .slv_wdata(slv_wdata), .slv_rdata(slv_rdata), .slv_ready(slv_ready),
        .slv_irq(slv_irq), .hw_int(hw_int)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
        int          waits;
        logic [31:0] sdata;
        logic [2:0]  exp_sel;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference address map as plain ranges.
    function automatic int ref_slave(input logic [31:0] a);
        if (a <= 32'h0000_3FFF)                        return 0;
        if (a >= 32'h0000_7F00 && a <= 32'h0000_7F0F) return 1;
        if (a >= 32'h0000_7F10 && a <= 32'h0000_7F1F) return 2;
        return -1;
    endfunction

    task automatic model(input logic [31:0] a, input logic we, input int waits, input logic [31:0] sdata,
                         output logic [2:0] esel, output int elat, output logic eerr, output logic [31:0] erd);
        int s;
        s = ref_slave(a);
        if (s < 0) begin
            esel = 3'b000; elat = 1; eerr = 1'b1; erd = DEAD;
        end else begin
            esel = 3'(1 << s);
            if (waits < TO) begin
                elat = waits + 2; eerr = 1'b0; erd = we ? 32'h0 : sdata + 32'(s);
            end else begin
                elat = TO + 1; eerr = 1'b1; erd = DEAD;
            end
        end
    endtask

    // Issue one access; the bench plays every slave, raising ready after 'waits' selected cycles.
    task automatic run_txn(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd,
                           input int waits, input logic [31:0] sdata,
                           output int lat, output int selcyc, output logic [2:0] selv, output logic err,
                           output logic [31:0] rd, output int nready, output bit hold_ok, output bit rd_hold);
        lat = 0; selcyc = 0; selv = '0; err = 1'b0; rd = '0; nready = 0; hold_ok = 1'b1; rd_hold = 1'b1;
        slv_rdata = {sdata + 32'd2, sdata + 32'd1, sdata};
        slv_ready = '0;
        cpu_addr = a; cpu_we = we; cpu_be = be; cpu_wdata = wd; cpu_req = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (slv_sel != '0) begin
                selcyc++;
                selv = selv | slv_sel;
                if (slv_addr !== a || slv_we !== we || slv_be !== be || slv_wdata !== wd) hold_ok = 1'b0;
            end
            slv_ready = (slv_sel != '0 && selcyc > waits) ? slv_sel : '0;
            if (cpu_ready) begin
                nready++;
                if (lat == 0) begin
                    lat = c; err = cpu_err; rd = cpu_rdata; cpu_req = 1'b0;
                end
            end
            if (lat > 0 && c == lat + 2) begin
                if (cpu_rdata !== rd) rd_hold = 1'b0;
                break;
            end
        end
        cpu_req = 1'b0;
        slv_ready = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, selcyc, nready, n, selc, seen;
        logic [2:0] selv, esel;
        logic err, eerr, done;
        logic [31:0] rd, erd, a, sd;
        bit hold_ok, rd_hold;

        vecs[0] = '{32'h0000_0010, 1'b0, 4'hF, 32'h0,      0,   32'hCAFE_0001, 3'b001, 2,  1'b0, 32'hCAFE_0001};
        vecs[1] = '{32'h0000_7F04, 1'b1, 4'hF, 32'h5,      3,   32'h1234_0000, 3'b010, 5,  1'b0, 32'h0};
        vecs[2] = '{32'h0000_5000, 1'b0, 4'hF, 32'h0,      0,   32'h2222_0000, 3'b000, 1,  1'b1, DEAD};
        vecs[3] = '{32'h0000_7F14, 1'b0, 4'hF, 32'h0,      255, 32'h3333_0000, 3'b100, 16, 1'b1, DEAD};
        vecs[4] = '{32'h0000_7F18, 1'b0, 4'hF, 32'h0,      1,   32'h1111_0000, 3'b100, 3,  1'b0, 32'h1111_0002};
        vecs[5] = '{32'h0000_3FFC, 1'b0, 4'hF, 32'h0,      14,  32'h5A5A_0000, 3'b001, 16, 1'b0, 32'h5A5A_0000};
        vecs[6] = '{32'h0000_4000, 1'b0, 4'hF, 32'h0,      0,   32'h4444_0000, 3'b000, 1,  1'b1, DEAD};
        vecs[7] = '{32'h0000_0100, 1'b1, 4'h3, 32'hABCD,   2,   32'h7777_0000, 3'b001, 4,  1'b0, 32'h0};

        reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = '0; cpu_addr = '0; cpu_wdata = '0;
        slv_rdata = '0; slv_ready = '0; slv_irq = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.cpu_ready", 32'(cpu_ready), 32'h0);
        chk("reset.cpu_err",   32'(cpu_err),   32'h0);
        chk("reset.slv_sel",   32'(slv_sel),   32'h0);
        chk("reset.cpu_rdata", cpu_rdata,      32'h0);
        chk("reset.hw_int",    32'(hw_int),    32'h0);
        chk("reset.slv_addr",  slv_addr,       32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wd, vecs[i].waits, vecs[i].sdata,
                    lat, selcyc, selv, err, rd, nready, hold_ok, rd_hold);
            chk($sformatf("vec%0d.sel", i),     32'(selv), 32'(vecs[i].exp_sel));
            chk($sformatf("vec%0d.latency", i), 32'(lat),  32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d.err", i),     32'(err),  32'(vecs[i].exp_err));
            chk($sformatf("vec%0d.rdata", i),   rd,        vecs[i].exp_rd);
            chk($sformatf("vec%0d.sel_cycles", i), 32'(selcyc),
                (vecs[i].exp_sel == 3'b000) ? 32'h0 : 32'(vecs[i].exp_lat - 1));
            chk($sformatf("vec%0d.ready_pulses", i), 32'(nready), 32'h1);
            chk($sformatf("vec%0d.slv_hold", i), 32'(hold_ok), 32'h1);
            chk($sformatf("vec%0d.rdata_hold", i), 32'(rd_hold), 32'h1);
        end

        // Reset during the second ACCESS cycle: abort silently, then recover.
        slv_ready = '0; cpu_addr = 32'h10; cpu_we = 1'b0; cpu_be = 4'hF; cpu_req = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst.sel_c1", 32'(slv_sel), 32'h1);
        @(posedge clk); #1;
        reset_n = 1'b0; #1;
        chk("mid_rst.sel_dropped", 32'(slv_sel),   32'h0);
        chk("mid_rst.no_ready",    32'(cpu_ready), 32'h0);
        chk("mid_rst.slv_addr",    slv_addr,       32'h0);
        cpu_req = 1'b0;
        seen = 0;
        repeat (3) begin @(posedge clk); #1; if (cpu_ready) seen++; end
        reset_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; if (cpu_ready) seen++; end
        chk("mid_rst.never_acked", 32'(seen), 32'h0);
        run_txn(32'h20, 1'b0, 4'hF, 32'h0, 0, 32'h0BAD_F00D, lat, selcyc, selv, err, rd, nready, hold_ok, rd_hold);
        chk("mid_rst.recover_lat",   32'(lat), 32'h2);
        chk("mid_rst.recover_rdata", rd,       32'h0BAD_F00D);

        // Timeout followed by a request held through RESP.
        sd = 32'h6060_0000;
        slv_rdata = {sd + 32'd2, sd + 32'd1, sd};
        slv_ready = '0; cpu_addr = 32'h7F14; cpu_we = 1'b0; cpu_req = 1'b1;
        n = 0; selc = 0; done = 1'b0;
        while (!done && n < 40) begin
            @(posedge clk); #1; n++;
            if (slv_sel != '0) selc++;
            if (cpu_ready) done = 1'b1;
        end
        chk("b2b.timeout_lat",  32'(n),       32'(TO + 1));
        chk("b2b.sel_cycles",   32'(selc),    32'(TO));
        chk("b2b.err",          32'(cpu_err), 32'h1);
        chk("b2b.rdata",        cpu_rdata,    DEAD);
        cpu_addr = 32'h24;
        @(posedge clk); #1;
        chk("b2b.idle_ready", 32'(cpu_ready), 32'h0);
        @(posedge clk); #1;
        chk("b2b.new_sel", 32'(slv_sel), 32'h1);
        slv_ready = slv_sel;
        @(posedge clk); #1;
        slv_ready = '0;
        chk("b2b.new_ready", 32'(cpu_ready), 32'h1);
        chk("b2b.new_err",   32'(cpu_err),   32'h0);
        chk("b2b.new_rdata", cpu_rdata,      sd);
        cpu_req = 1'b0;
        @(posedge clk); #1;

        // Interrupt lag.
        slv_irq = 3'b011; #1;
        chk("irq.no_comb_path", 32'(hw_int), 32'h0);
        @(posedge clk); #1;
        chk("irq.set", 32'(hw_int), 32'h03);
        slv_irq = 3'b000; #1;
        chk("irq.still_set", 32'(hw_int), 32'h03);
        @(posedge clk); #1;
        chk("irq.clear", 32'(hw_int), 32'h0);
        for (int i = 0; i < 10; i++) begin
            logic [2:0] v;
            v = 3'($urandom_range(0, 7));
            slv_irq = v;
            @(posedge clk); #1;
            chk($sformatf("irq.rand%0d", i), 32'(hw_int), 32'(v));
        end
        slv_irq = '0;

        // Random accesses against the reference model.
        for (int i = 0; i < 40; i++) begin
            int kind, waits;
            logic we;
            kind  = $urandom_range(0, 3);
            waits = $urandom_range(0, 20);
            we    = 1'($urandom_range(0, 1));
            case (kind)
                0: a = $urandom & 32'h0000_3FFF;
                1: a = 32'h7F00 | ($urandom & 32'hF);
                2: a = 32'h7F10 | ($urandom & 32'hF);
                default: begin
                    a = $urandom;
                    for (int t = 0; t < 20 && ref_slave(a) >= 0; t++) a = $urandom;
                end
            endcase
            sd = $urandom;
            model(a, we, waits, sd, esel, lat, eerr, erd);
            n = lat;
            run_txn(a, we, 4'($urandom_range(0, 15)), $urandom, waits, sd,
                    lat, selcyc, selv, err, rd, nready, hold_ok, rd_hold);
            chk($sformatf("rnd%0d.sel", i),     32'(selv), 32'(esel));
            chk($sformatf("rnd%0d.latency", i), 32'(lat),  32'(n));
            chk($sformatf("rnd%0d.err", i),     32'(err),  32'(eerr));
            chk($sformatf("rnd%0d.rdata", i),   rd,        erd);
            chk($sformatf("rnd%0d.pulses", i),  32'(nready), 32'h1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sys_bus_bridge.md
# sys_bus_bridge

Parametrised, multi-slave system bus bridge between the CPU data port and its memory-mapped slaves: data memory, timers and future peripherals. It registers each CPU access and decodes the address against per-slave base/mask windows. It then runs a wait-state handshake with the selected slave and returns read data with a one-cycle `cpu_ready` pulse. Unmapped and timed-out accesses complete with an error flag and a fixed dead value, and slave interrupt lines are registered into the CPU's 6-bit hardware-interrupt vector.

## Interface
- `NUM_SLAVES`, 3: number of slave channels, 1..8.
- `SLV_BASE`, {32'h7F10, 32'h7F00, 32'h0}: packed `NUM_SLAVES*32`; base address of slave i in slice i.
- `SLV_MASK`, {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_C000}: packed `NUM_SLAVES*32`; address-compare mask of slave i.
- `TIMEOUT`, 15: maximum number of ACCESS cycles allowed without `slv_ready`, 1..255.
- `DEAD_VALUE`, 32'h18373695: read data returned on error.
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: access request, level; the CPU holds it and all `cpu_*` inputs stable until `cpu_ready`.
- `cpu_we` in 1: 1 = write.
- `cpu_be` in 4: byte enables.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: write data.
- `cpu_rdata` out 32: read data, valid while `cpu_ready`=1.
- `cpu_ready` out 1: one-cycle completion pulse.
- `cpu_err` out 1: qualifies `cpu_ready`; 1 = unmapped or timeout.
- `slv_sel` out `NUM_SLAVES`: one-hot slave select.
- `slv_we`, `slv_be`, `slv_addr`, `slv_wdata` out 1/4/32/32: registered copies of the CPU request, broadcast to all slaves.
- `slv_rdata` in `NUM_SLAVES*32`: read data of slave i in slice i.
- `slv_ready` in `NUM_SLAVES`: slave i completes the access in the current cycle.
- `slv_irq` in `NUM_SLAVES`: level interrupt request from each slave.
- `hw_int` out 6: registered interrupt vector to the CPU.

## Operation
- Decode: slave i hits when `(addr & SLV_MASK[i]) == SLV_BASE[i]`. If several slaves hit, the lowest index wins. No hit means unmapped.
- States are IDLE, ACCESS and RESP.
- IDLE:
  - With `cpu_req`=1, latch addr, wdata, we and be.
  - On a hit, go to ACCESS.
  - On no hit, go to RESP with err=1 and rdata=`DEAD_VALUE`.
- ACCESS:
  - `slv_sel[i]`=1 for the whole state.
  - The timeout counter increments from 0 every cycle.
  - If `slv_ready[i]`=1, capture `slv_rdata[i]` (0 for writes) and go to RESP with err=0.
  - If the counter reaches `TIMEOUT`-1 without ready, go to RESP with err=1 and rdata=`DEAD_VALUE`.
  - Ready wins over timeout in the same cycle.
- RESP: `cpu_ready`=1 for exactly one cycle, then IDLE. `cpu_req` is only sampled in IDLE, so a request held through RESP starts a new access on the next cycle.
- `slv_ready` is ignored on non-selected channels and outside ACCESS.
- Interrupts: `hw_int[k]` = `slv_irq[k]` delayed by one flop for k < min(NUM_SLAVES,6); all other bits are 0.
- Reset (asynchronous, at any point including mid-ACCESS):
  - State goes to IDLE and the counter clears.
  - `slv_sel`, `cpu_ready`, `cpu_err`, `hw_int` and all `slv_*` outputs reset to 0.
  - `cpu_rdata` resets to 0.
  - The aborted access is never acknowledged.

## Timing
- Request seen at edge 0. ACCESS runs in cycle 1; a zero-wait slave asserts ready in cycle 1; `cpu_ready` is asserted in cycle 2. Minimum latency is 2 cycles; each wait state adds 1.
- An unmapped access raises `cpu_ready` in cycle 1.
- A timeout raises `cpu_ready` in cycle `TIMEOUT`+1, and `slv_sel` drops on that same edge.
- `slv_*` outputs are registered, with no combinational path from `cpu_*`.
- `cpu_rdata` holds its value after RESP until the next completion.
- `hw_int` lags `slv_irq` by one cycle.

## Structure
- `bridge_pkg` holds:
  - the state enum;
  - the default map constants (`DM_BASE`/`MASK`, `TIMER0_BASE`/`MASK`, `TIMER1_BASE`/`MASK`);
  - `DEAD_VALUE`;
  - the width of the timeout counter, `$clog2(256)`.
- One combinational sub-module, `bridge_addr_decoder`, parametrised by `NUM_SLAVES`/`SLV_BASE`/`SLV_MASK`. It takes addr and outputs the one-hot `hit` plus `any_hit`.
- The FSM, latches, counter and interrupt flops live in `sys_bus_bridge`.

## Test plan
- Read at 0x0000_0010 with the DM zero-wait returning 0xCAFE0001: `slv_sel`=001 in cycle 1, `cpu_ready`=1 with `cpu_rdata`=0xCAFE0001 and `cpu_err`=0 in cycle 2.
- Write 0x5 to 0x7F04 with timer0 holding ready low for 3 cycles: `slv_sel`=010 for 4 cycles with `slv_wdata`=0x5 and `slv_be`=1111 throughout, one `cpu_ready` pulse.
- Read at 0x0000_5000 (unmapped): no `slv_sel`; `cpu_ready` and `cpu_err`=1 in cycle 1; `cpu_rdata`=0x18373695.
- Access 0x7F14 with timer1 ready stuck low and `TIMEOUT`=15: `slv_sel`=100 for exactly 15 cycles, then `cpu_err`=1 and `DEAD_VALUE`; a back-to-back request starts ACCESS the cycle after RESP.
- `reset_n` low in the 2nd ACCESS cycle: `slv_sel`=0 immediately, no `cpu_ready`; after release, a new DM read completes normally.
- `slv_irq`=011 → `hw_int`=000011 one cycle later; `slv_irq`=000 → `hw_int` back to 0 one cycle later.
